// File: rtl/msk_lbox_seq.sv
// Masked L-box layer sequencer: streams four masked 32-bit rows through one
// external dual L-box as two row pairs, with valid/ready handshakes on both sides.
module msk_lbox_seq #(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inverse,
    input  logic [128*d-1:0] in_state,
    output logic [32*d-1:0]  lb_x,
    output logic [32*d-1:0]  lb_y,
    output logic             lb_inverse,
    input  logic [32*d-1:0]  lb_a,
    input  logic [32*d-1:0]  lb_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [128*d-1:0] out_state,
    output logic             busy
);
    localparam int unsigned RW = 32 * d;

    typedef enum logic [1:0] {IDLE, PAIR0, PAIR1, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] r0;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [RW-1:0] r3;
    logic          inv_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = PAIR0;
            PAIR0:   state_nxt = PAIR1;
            PAIR1:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Rows are moved as whole share-interleaved vectors; shares are never mixed here.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r0    <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            inv_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r0    <= in_state[0*RW +: RW];
                        r1    <= in_state[1*RW +: RW];
                        r2    <= in_state[2*RW +: RW];
                        r3    <= in_state[3*RW +: RW];
                        inv_q <= in_inverse;
                    end
                end
                PAIR0: begin
                    r0 <= lb_a;
                    r1 <= lb_b;
                end
                PAIR1: begin
                    r2 <= lb_a;
                    r3 <= lb_b;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        lb_x       = r0;
        lb_y       = r1;
        lb_inverse = inv_q;
        out_state  = {r3, r2, r1, r0};
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            PAIR1: begin
                lb_x = r2;
                lb_y = r3;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_msk_lbox_seq.sv
// Bench for msk_lbox_seq: d=2 and d=4 instances run in lockstep against a
// share-wise Clyde L-box environment and an unmasked golden L-box model.
module tb_msk_lbox_seq;
    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_inverse = 1'b0;
    logic         out_ready = 1'b1;
    logic [255:0] in_state2;
    logic [511:0] in_state4;
    logic         in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4, lb_inv2, lb_inv4;
    logic [63:0]  lb_x2, lb_y2, lb_a2, lb_b2;
    logic [127:0] lb_x4, lb_y4, lb_a4, lb_b4;
    logic [255:0] out_state2;
    logic [511:0] out_state4;
    logic [255:0] stub2, stub4;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    // Clyde L-box on one (x, y) row pair; returns {x', y'}
    function automatic logic [63:0] lbox(input logic [31:0] x, input logic [31:0] y, input bit inv);
        logic [31:0] a, b, c, e;
        if (!inv) begin
            a = x ^ rotr(x, 12);  b = y ^ rotr(y, 12);
            a = a ^ rotr(a, 3);   b = b ^ rotr(b, 3);
            a = a ^ rotr(x, 17);  b = b ^ rotr(y, 17);
            c = a ^ rotr(a, 31);  e = b ^ rotr(b, 31);
            a = a ^ rotr(e, 26);  b = b ^ rotr(c, 25);
            a = a ^ rotr(c, 15);  b = b ^ rotr(e, 15);
        end else begin
            a = x ^ rotr(x, 25);  b = y ^ rotr(y, 25);
            c = x ^ rotr(a, 31);  e = y ^ rotr(b, 31);
            c = c ^ rotr(a, 20);  e = e ^ rotr(b, 20);
            a = c ^ rotr(c, 31);  b = e ^ rotr(e, 31);
            c = c ^ rotr(b, 26);  e = e ^ rotr(a, 25);
            a = a ^ rotr(c, 17);  b = b ^ rotr(e, 17);
            a = rotr(a, 16);      b = rotr(b, 16);
        end
        return {a, b};
    endfunction

    // Share j of row r, bit k at 32*nsh*r + k*nsh + j
    function automatic logic [31:0] shr(input logic [511:0] s, input int nsh, input int r, input int j);
        logic [31:0] v;
        for (int k = 0; k < 32; k++) v[k] = s[32*nsh*r + k*nsh + j];
        return v;
    endfunction

    function automatic logic [127:0] unmask_state(input logic [511:0] s, input int nsh);
        logic [127:0] u;
        u = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < nsh; j++) u[32*r +: 32] = u[32*r +: 32] ^ shr(s, nsh, r, j);
        return u;
    endfunction

    function automatic logic [511:0] mask_state(input logic [127:0] u, input int nsh, input bit zero);
        logic [511:0] s;
        logic [31:0]  acc, sh;
        s = '0;
        for (int r = 0; r < 4; r++) begin
            acc = u[32*r +: 32];
            for (int j = 0; j < nsh; j++) begin
                if (j == nsh - 1) sh = acc;
                else begin
                    sh  = zero ? 32'h0 : $urandom;
                    acc = acc ^ sh;
                end
                for (int k = 0; k < 32; k++) s[32*nsh*r + k*nsh + j] = sh[k];
            end
        end
        return s;
    endfunction

    // Expected masked layer: each share of pair (0,1) and (2,3) goes through the L-box
    function automatic logic [511:0] layer_masked(input logic [511:0] s, input int nsh, input bit inv);
        logic [511:0] o;
        logic [63:0]  ab;
        o = '0;
        for (int j = 0; j < nsh; j++)
            for (int p = 0; p < 2; p++) begin
                ab = lbox(shr(s, nsh, 2*p, j), shr(s, nsh, 2*p + 1, j), inv);
                for (int k = 0; k < 32; k++) begin
                    o[32*nsh*(2*p) + k*nsh + j]     = ab[32 + k];
                    o[32*nsh*(2*p + 1) + k*nsh + j] = ab[k];
                end
            end
        return o;
    endfunction

    function automatic logic [127:0] golden(input logic [127:0] u, input bit inv);
        logic [63:0] p01, p23;
        p01 = lbox(u[0 +: 32], u[32 +: 32], inv);
        p23 = lbox(u[64 +: 32], u[96 +: 32], inv);
        return {p23[31:0], p23[63:32], p01[31:0], p01[63:32]};
    endfunction

    // Share-wise dual L-box seen by the DUT: returns {a, b}
    function automatic logic [255:0] stub(input logic [127:0] x, input logic [127:0] y, input int nsh, input bit inv);
        logic [127:0] a, b;
        logic [63:0]  ab;
        logic [31:0]  xs, ys;
        a = '0;
        b = '0;
        for (int j = 0; j < nsh; j++) begin
            for (int k = 0; k < 32; k++) begin
                xs[k] = x[k*nsh + j];
                ys[k] = y[k*nsh + j];
            end
            ab = lbox(xs, ys, inv);
            for (int k = 0; k < 32; k++) begin
                a[k*nsh + j] = ab[32 + k];
                b[k*nsh + j] = ab[k];
            end
        end
        return {a, b};
    endfunction

    assign stub2 = stub({64'b0, lb_x2}, {64'b0, lb_y2}, 2, lb_inv2);
    assign lb_a2 = stub2[191:128];
    assign lb_b2 = stub2[63:0];
    assign stub4 = stub(lb_x4, lb_y4, 4, lb_inv4);
    assign lb_a4 = stub4[255:128];
    assign lb_b4 = stub4[127:0];

    msk_lbox_seq #(.d(2)) dut2 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready2), .in_inverse(in_inverse),
        .in_state(in_state2), .lb_x(lb_x2), .lb_y(lb_y2), .lb_inverse(lb_inv2), .lb_a(lb_a2),
        .lb_b(lb_b2), .out_valid(out_valid2), .out_ready(out_ready), .out_state(out_state2), .busy(busy2)
    );

    msk_lbox_seq #(.d(4)) dut4 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready4), .in_inverse(in_inverse),
        .in_state(in_state4), .lb_x(lb_x4), .lb_y(lb_y4), .lb_inverse(lb_inv4), .lb_a(lb_a4),
        .lb_b(lb_b4), .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4), .busy(busy4)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_inputs(input logic [127:0] u, input bit zero);
        logic [511:0] s;
        s = mask_state(u, 2, zero);
        in_state2 = s[255:0];
        in_state4 = mask_state(u, 4, zero);
    endtask

    // Offers the current in_state at a negedge in IDLE and follows the layer back to IDLE
    task automatic run_layer(input bit inv, input int hold, input bit toggle, input string name);
        logic [511:0] e2, e4;
        logic [127:0] g2, g4;
        logic [5:0]   ef;
        e2 = layer_masked({256'b0, in_state2}, 2, inv);
        e4 = layer_masked(in_state4, 4, inv);
        g2 = golden(unmask_state({256'b0, in_state2}, 2), inv);
        g4 = golden(unmask_state(in_state4, 4), inv);
        n_cmp++;
        if ({in_ready2, in_ready4} !== 2'b11) begin
            n_bad++; $display("FAIL %s idle_ready: got %b want 11", name, {in_ready2, in_ready4});
        end
        in_inverse = inv;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = (hold > 0);
        for (int c = 1; c <= 3; c++) begin
            ef = {2'b00, 2'b11, {2{c == 3}}};
            n_cmp++;
            if ({in_ready2, in_ready4, busy2, busy4, out_valid2, out_valid4} !== ef) begin
                n_bad++; $display("FAIL %s flags_c%0d: got %b want %b", name, c,
                                  {in_ready2, in_ready4, busy2, busy4, out_valid2, out_valid4}, ef);
            end
            n_cmp++;
            if ({lb_inv2, lb_inv4} !== {inv, inv}) begin
                n_bad++; $display("FAIL %s lb_inverse_c%0d: got %b want %b", name, c, {lb_inv2, lb_inv4}, {inv, inv});
            end
            if (toggle) in_inverse = ~in_inverse;
            if (hold > 0) set_inputs(rand128(), 1'b0);
            if (c < 3) @(negedge clk);
        end
        n_cmp++;
        if ({out_state2, out_state4} !== {e2[255:0], e4}) begin
            n_bad++; $display("FAIL %s masked_out: got %h want %h", name, {out_state2, out_state4}, {e2[255:0], e4});
        end
        n_cmp++;
        if ({unmask_state({256'b0, out_state2}, 2), unmask_state(out_state4, 4)} !== {g2, g4}) begin
            n_bad++; $display("FAIL %s golden_out: got %h want %h", name,
                              {unmask_state({256'b0, out_state2}, 2), unmask_state(out_state4, 4)}, {g2, g4});
        end
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                n_cmp++;
                if ({out_valid2, out_valid4, in_ready2, in_ready4} !== 4'b1100) begin
                    n_bad++; $display("FAIL %s hold_flags_%0d: got %b want 1100", name, h,
                                      {out_valid2, out_valid4, in_ready2, in_ready4});
                end
                n_cmp++;
                if ({out_state2, out_state4} !== {e2[255:0], e4}) begin
                    n_bad++; $display("FAIL %s hold_state_%0d: got %h want %h", name, h,
                                      {out_state2, out_state4}, {e2[255:0], e4});
                end
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4} !== 6'b110000) begin
            n_bad++; $display("FAIL %s back_to_idle: got %b want 110000", name,
                              {in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4});
        end
        n_cmp++;
        if ({out_state2, out_state4} !== {e2[255:0], e4}) begin
            n_bad++; $display("FAIL %s idle_keeps_out: got %h want %h", name, {out_state2, out_state4}, {e2[255:0], e4});
        end
    endtask

    task automatic test_reset();
        set_inputs('0, 1'b1);
        #1 nrst = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4, lb_inv2, lb_inv4} !== 8'b11000000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 11000000",
                              {in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4, lb_inv2, lb_inv4});
        end
        n_cmp++;
        if ({out_state2, out_state4} !== 768'b0) begin
            n_bad++; $display("FAIL reset_state: got %h want 0", {out_state2, out_state4});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready2, in_ready4, busy2, busy4} !== 4'b1100) begin
            n_bad++; $display("FAIL release_ready: got %b want 1100", {in_ready2, in_ready4, busy2, busy4});
        end
    endtask

    task automatic test_zero();
        set_inputs('0, 1'b1);
        run_layer(1'b0, 0, 1'b0, "zero");
        n_cmp++;
        if ({out_state2, out_state4} !== 768'b0) begin
            n_bad++; $display("FAIL zero_out: got %h want 0", {out_state2, out_state4});
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] u;
        for (int i = 0; i < 4; i++) begin
            u = rand128();
            set_inputs(u, 1'b0);
            run_layer(1'b0, 0, 1'b0, "rt_fwd");
            in_state2 = out_state2;
            in_state4 = out_state4;
            run_layer(1'b1, 0, 1'b0, "rt_inv");
            n_cmp++;
            if ({unmask_state({256'b0, out_state2}, 2), unmask_state(out_state4, 4)} !== {u, u}) begin
                n_bad++; $display("FAIL roundtrip_%0d: got %h want %h", i,
                                  {unmask_state({256'b0, out_state2}, 2), unmask_state(out_state4, 4)}, {u, u});
            end
        end
    endtask

    task automatic test_hold();
        set_inputs(rand128(), 1'b0);
        run_layer(1'b1, 10, 1'b1, "hold_inv");
        set_inputs(rand128(), 1'b0);
        run_layer(1'b0, 10, 1'b0, "hold_fwd");
    endtask

    task automatic test_back_to_back();
        logic [511:0] e2, e4;
        logic         inv_acc;
        int           ph;
        e2 = '0; e4 = '0; inv_acc = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            ph = c % 4;
            n_cmp++;
            if ({in_ready2, in_ready4} !== {2{ph == 0}}) begin
                n_bad++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, {in_ready2, in_ready4}, {2{ph == 0}});
            end
            if (ph == 1 || ph == 2) begin
                n_cmp++;
                if ({lb_inv2, lb_inv4} !== {inv_acc, inv_acc}) begin
                    n_bad++; $display("FAIL b2b_lb_inverse_c%0d: got %b want %b", c, {lb_inv2, lb_inv4}, {inv_acc, inv_acc});
                end
            end
            if (ph == 3) begin
                n_cmp++;
                if ({out_valid2, out_valid4, out_state2, out_state4} !== {2'b11, e2[255:0], e4}) begin
                    n_bad++; $display("FAIL b2b_out_c%0d: got %b %h want 11 %h", c, {out_valid2, out_valid4},
                                      {out_state2, out_state4}, {e2[255:0], e4});
                end
            end
            set_inputs(rand128(), 1'b0);
            in_inverse = ~in_inverse;
            if (ph == 0) begin
                inv_acc = in_inverse;
                e2 = layer_masked({256'b0, in_state2}, 2, in_inverse);
                e4 = layer_masked(in_state4, 4, in_inverse);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready2, in_ready4} !== 2'b11) begin
            n_bad++; $display("FAIL b2b_final_ready: got %b want 11", {in_ready2, in_ready4});
        end
    endtask

    task automatic test_reset_mid();
        set_inputs(rand128(), 1'b0);
        in_inverse = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy2, busy4, out_valid2, out_valid4} !== 4'b1100) begin
            n_bad++; $display("FAIL rstmid_pair1: got %b want 1100", {busy2, busy4, out_valid2, out_valid4});
        end
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4, lb_inv2, lb_inv4} !== 8'b11000000) begin
            n_bad++; $display("FAIL rstmid_flags: got %b want 11000000",
                              {in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4, lb_inv2, lb_inv4});
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4} !== 6'b110000) begin
                n_bad++; $display("FAIL rstmid_after_c%0d: got %b want 110000", c,
                                  {in_ready2, in_ready4, out_valid2, out_valid4, busy2, busy4});
            end
            n_cmp++;
            if ({out_state2, out_state4} !== 768'b0) begin
                n_bad++; $display("FAIL rstmid_rows_c%0d: got %h want 0", c, {out_state2, out_state4});
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] u;
        for (int i = 0; i < 1000; i++) begin
            u = rand128();
            set_inputs(u, 1'b0);
            run_layer(1'b0, 0, 1'($urandom_range(1, 0)), "rand_fwd");
            set_inputs(u, 1'b0);
            run_layer(1'b1, 0, 1'($urandom_range(1, 0)), "rand_inv");
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_roundtrip();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
